// File: rtl/dram_cmd_sched_if.sv
// Request/command bundle between the aged request queue, dram_cmd_sched and the DIMM side.
// global_defs carries the request record and the address-field layout shared by every stage.
`timescale 1ns/1ps
package global_defs;
  localparam int ADDR_W = 32;
  localparam int BG_W   = 2;
  localparam int BANK_W = 2;
  localparam int ROW_W  = 16;
  localparam int COL_W  = 10;

  localparam logic [ADDR_W-1:0] column_mask     = 32'h0000_03FF;
  localparam logic [ADDR_W-1:0] bank_mask       = 32'h0000_0C00;
  localparam logic [ADDR_W-1:0] bank_group_mask = 32'h0000_3000;
  localparam logic [ADDR_W-1:0] row_mask        = 32'h3FFF_C000;
  localparam int COLUMN_OFFSET     = 0;
  localparam int BANK_OFFSET       = 10;
  localparam int BANK_GROUP_OFFSET = 12;
  localparam int ROW_OFFSET        = 14;

  localparam logic [1:0] OP_READ   = 2'd0;
  localparam logic [1:0] OP_WRITE  = 2'd1;
  localparam logic [1:0] OP_IFETCH = 2'd2;

  typedef struct packed {
    logic [1:0]        opcode;
    logic [ADDR_W-1:0] address;
  } parser_out_struct;
endpackage

interface dram_cmd_sched_if;
  import global_defs::*;
  // req_valid is a one-cycle strobe with no backpressure: it samples req_in on that edge,
  // and a strobe arriving while the buffer is full with no pop on the same edge is dropped.
  parser_out_struct   req_in;
  logic               req_valid;
  logic               cmd_valid;
  logic [1:0]         cmd;
  logic               cmd_wr;
  logic [BG_W-1:0]    cmd_bg;
  logic [BANK_W-1:0]  cmd_bank;
  logic [ROW_W-1:0]   cmd_row;
  logic [COL_W-1:0]   cmd_col;
  logic               req_done;
  logic               buf_full;
  logic               buf_empty;
  logic [15:0]        drop_count;
  logic [2:0]         state_dbg;

  modport slave (
    input  req_in, req_valid,
    output cmd_valid, cmd, cmd_wr, cmd_bg, cmd_bank, cmd_row, cmd_col,
           req_done, buf_full, buf_empty, drop_count, state_dbg
  );
  modport master (
    output req_in, req_valid,
    input  cmd_valid, cmd, cmd_wr, cmd_bg, cmd_bank, cmd_row, cmd_col,
           req_done, buf_full, buf_empty, drop_count, state_dbg
  );
endinterface

// File: rtl/dram_cmd_sched.sv
// In-order DRAM command scheduler: buffers queue releases, tracks open rows per bank and
// issues PRE/ACT/RD/WR on the half-rate DIMM clock with tRP/tRCD/CL/CWL/tBURST spacing.
`timescale 1ns/1ps
module dram_cmd_sched
  import global_defs::*;
#(
  parameter int IN_DEPTH = 4,
  parameter int T_RP     = 24,
  parameter int T_RCD    = 24,
  parameter int T_CL     = 24,
  parameter int T_CWL    = 20,
  parameter int T_BURST  = 4
) (
  input  logic            CPU_clock,
  input  logic            rst_n,
  dram_cmd_sched_if.slave bus
);

  localparam int PTR_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int CNT_W = $clog2(IN_DEPTH) + 1;
  localparam logic [1:0] CMD_NOP = 2'd0;
  localparam logic [1:0] CMD_ACT = 2'd1;
  localparam logic [1:0] CMD_RW  = 2'd2;
  localparam logic [1:0] CMD_PRE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_RW, S_WAIT_DATA
  } state_e;

  state_e             r_state, w_state_nxt;
  logic               r_phase;
  logic [7:0]         r_cnt, w_cnt_nxt;

  parser_out_struct   r_buf [IN_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic               r_buf_full, r_buf_empty;
  logic [15:0]        r_drop_count;

  logic               r_wr;
  logic [BG_W-1:0]    r_bg;
  logic [BANK_W-1:0]  r_bank;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;

  logic [15:0]        r_ot_valid;
  logic [ROW_W-1:0]   r_ot_row [16];

  logic               r_cmd_valid, r_cmd_wr, r_req_done;
  logic [1:0]         r_cmd;
  logic [BG_W-1:0]    r_cmd_bg;
  logic [BANK_W-1:0]  r_cmd_bank;
  logic [ROW_W-1:0]   r_cmd_row;
  logic [COL_W-1:0]   r_cmd_col;

  logic               w_tick, w_full, w_pop, w_push, w_drop;
  logic [3:0]         w_idx;
  logic               w_open, w_hit;
  logic [1:0]         w_cmd_nxt;
  logic               w_done_nxt;
  parser_out_struct   w_head;

  // A DIMM tick is the CPU edge that closes the second half of a DIMM cycle.
  assign w_tick  = r_phase;
  assign w_full  = (r_count == CNT_W'(IN_DEPTH));
  assign w_pop   = w_tick && (r_state == S_IDLE) && (r_count != '0);
  assign w_push  = bus.req_valid && (!w_full || w_pop);
  assign w_drop  = bus.req_valid && w_full && !w_pop;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_head  = r_buf[r_rd_ptr];

  assign w_idx   = {r_bg, r_bank};
  assign w_open  = r_ot_valid[w_idx];
  assign w_hit   = w_open && (r_ot_row[w_idx] == r_row);

  always_ff @(posedge CPU_clock) begin
    if (w_push) r_buf[r_wr_ptr] <= bus.req_in;
  end

  always_ff @(posedge CPU_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_buf_full   <= 1'b0;
      r_buf_empty  <= 1'b1;
      r_drop_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count     <= w_count_nxt;
      r_buf_full  <= (w_count_nxt == CNT_W'(IN_DEPTH));
      r_buf_empty <= (w_count_nxt == '0);
      if (w_drop && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  // Wait states exit one tick early so the next command lands exactly T ticks after the last.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cmd_nxt   = CMD_NOP;
    w_done_nxt  = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        S_IDLE:     if (r_count != '0) w_state_nxt = S_DECODE;
        S_DECODE: begin
          if (w_hit)        w_state_nxt = S_RW;
          else if (!w_open) w_state_nxt = S_ACT;
          else              w_state_nxt = S_PRE;
        end
        S_PRE: begin
          w_cmd_nxt   = CMD_PRE;
          w_cnt_nxt   = 8'(T_RP - 1);
          w_state_nxt = S_WAIT_RP;
        end
        S_WAIT_RP: begin
          if (r_cnt <= 8'd1) w_state_nxt = S_ACT;
          else               w_cnt_nxt   = r_cnt - 8'd1;
        end
        S_ACT: begin
          w_cmd_nxt   = CMD_ACT;
          w_cnt_nxt   = 8'(T_RCD - 1);
          w_state_nxt = S_WAIT_RCD;
        end
        S_WAIT_RCD: begin
          if (r_cnt <= 8'd1) w_state_nxt = S_RW;
          else               w_cnt_nxt   = r_cnt - 8'd1;
        end
        S_RW: begin
          w_cmd_nxt   = CMD_RW;
          w_cnt_nxt   = r_wr ? 8'(T_CWL + T_BURST - 1) : 8'(T_CL + T_BURST - 1);
          w_state_nxt = S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          if (r_cnt == 8'd0) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CPU_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_phase    <= 1'b0;
      r_cnt      <= '0;
      r_wr       <= 1'b0;
      r_bg       <= '0;
      r_bank     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_ot_valid <= '0;
      for (int i = 0; i < 16; i++) r_ot_row[i] <= '0;
    end else begin
      r_phase <= ~r_phase;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_pop) begin
        r_wr   <= (w_head.opcode == OP_WRITE);
        r_bg   <= BG_W'((w_head.address & bank_group_mask) >> BANK_GROUP_OFFSET);
        r_bank <= BANK_W'((w_head.address & bank_mask) >> BANK_OFFSET);
        r_row  <= ROW_W'((w_head.address & row_mask) >> ROW_OFFSET);
        r_col  <= COL_W'((w_head.address & column_mask) >> COLUMN_OFFSET);
      end
      if (w_cmd_nxt == CMD_PRE) r_ot_valid[w_idx] <= 1'b0;
      if (w_cmd_nxt == CMD_ACT) begin
        r_ot_valid[w_idx] <= 1'b1;
        r_ot_row[w_idx]   <= r_row;
      end
    end
  end

  always_ff @(posedge CPU_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd       <= CMD_NOP;
      r_cmd_wr    <= 1'b0;
      r_cmd_bg    <= '0;
      r_cmd_bank  <= '0;
      r_cmd_row   <= '0;
      r_cmd_col   <= '0;
      r_req_done  <= 1'b0;
    end else begin
      r_cmd_valid <= (w_cmd_nxt != CMD_NOP);
      r_cmd       <= w_cmd_nxt;
      r_req_done  <= w_done_nxt;
      if (w_cmd_nxt != CMD_NOP) begin
        r_cmd_bg   <= r_bg;
        r_cmd_bank <= r_bank;
      end
      if (w_cmd_nxt == CMD_ACT) r_cmd_row <= r_row;
      if (w_cmd_nxt == CMD_RW) begin
        r_cmd_col <= r_col;
        r_cmd_wr  <= r_wr;
      end
    end
  end

  assign bus.cmd_valid  = r_cmd_valid;
  assign bus.cmd        = r_cmd;
  assign bus.cmd_wr     = r_cmd_wr;
  assign bus.cmd_bg     = r_cmd_bg;
  assign bus.cmd_bank   = r_cmd_bank;
  assign bus.cmd_row    = r_cmd_row;
  assign bus.cmd_col    = r_cmd_col;
  assign bus.req_done   = r_req_done;
  assign bus.buf_full   = r_buf_full;
  assign bus.buf_empty  = r_buf_empty;
  assign bus.drop_count = r_drop_count;
  assign bus.state_dbg  = r_state;

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Bench for dram_cmd_sched: directed and random requests checked against a per-request
// command/latency model and an open-row table kept at the address-arithmetic level.
`timescale 1ns/1ps
module tb_dram_cmd_sched;
  import global_defs::*;

  localparam int IN_DEPTH = 4;
  localparam int T_RP     = 24;
  localparam int T_RCD    = 24;
  localparam int T_CL     = 24;
  localparam int T_CWL    = 20;
  localparam int T_BURST  = 4;

  localparam logic [2:0] K_ACT  = 3'd1;
  localparam logic [2:0] K_RW   = 3'd2;
  localparam logic [2:0] K_PRE  = 3'd3;
  localparam logic [2:0] K_DONE = 3'd4;
  localparam logic [7:0] GAP_X  = 8'hFF;

  typedef struct packed {
    logic [2:0]  kind;
    logic        wr;
    logic [1:0]  bg;
    logic [1:0]  bank;
    logic [15:0] row;
    logic [9:0]  col;
    logic [7:0]  gap;
  } ev_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dram_cmd_sched_if bus();

  dram_cmd_sched #(
    .IN_DEPTH(IN_DEPTH), .T_RP(T_RP), .T_RCD(T_RCD),
    .T_CL(T_CL), .T_CWL(T_CWL), .T_BURST(T_BURST)
  ) dut (
    .CPU_clock(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_cyc = 0;
  int n_done   = 0;
  int n_exp_done = 0;

  ev_t exp_q[$];
  ev_t obs_q[$];

  logic        ot_v [16];
  logic [15:0] ot_row [16];

  always @(posedge clk) cyc++;

  // monitor: every command pulse and every completion becomes an event with its spacing
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.cmd_valid || bus.req_done) begin
        ev_t e;
        int d;
        d = cyc - last_cyc;
        e = '0;
        e.gap  = (d > 254) ? 8'd254 : 8'(d);
        e.kind = bus.req_done ? K_DONE : {1'b0, bus.cmd};
        e.wr   = bus.cmd_wr;
        e.bg   = bus.cmd_bg;
        e.bank = bus.cmd_bank;
        e.row  = bus.cmd_row;
        e.col  = bus.cmd_col;
        obs_q.push_back(e);
        last_cyc = cyc;
        if (bus.req_done) n_done++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_addr(int bg, int bank, int row, int col);
    return 32'(row * 16384 + bg * 4096 + bank * 1024 + col);
  endfunction

  // reference: one request in arrival order -> expected command list with spacing
  task automatic model_req(input logic [1:0] op, input logic [31:0] addr);
    int bg, bank, row, col, idx;
    bit wr;
    ev_t e;
    bg   = int'((addr / 4096) % 4);
    bank = int'((addr / 1024) % 4);
    row  = int'((addr / 16384) % 65536);
    col  = int'(addr % 1024);
    idx  = bg * 4 + bank;
    wr   = (op == OP_WRITE);
    e = '0;
    e.bg = 2'(bg); e.bank = 2'(bank); e.row = 16'(row); e.col = 10'(col); e.wr = wr;
    if (ot_v[idx] && ot_row[idx] == 16'(row)) begin
      e.kind = K_RW;  e.gap = GAP_X;            exp_q.push_back(e);
    end else if (!ot_v[idx]) begin
      e.kind = K_ACT; e.gap = GAP_X;            exp_q.push_back(e);
      e.kind = K_RW;  e.gap = 8'(2 * T_RCD);    exp_q.push_back(e);
    end else begin
      e.kind = K_PRE; e.gap = GAP_X;            exp_q.push_back(e);
      e.kind = K_ACT; e.gap = 8'(2 * T_RP);     exp_q.push_back(e);
      e.kind = K_RW;  e.gap = 8'(2 * T_RCD);    exp_q.push_back(e);
    end
    e.kind = K_DONE;
    e.gap  = 8'(2 * ((wr ? T_CWL : T_CL) + T_BURST));
    exp_q.push_back(e);
    ot_v[idx]   = 1'b1;
    ot_row[idx] = 16'(row);
    n_exp_done++;
  endtask

  // driver tasks
  task automatic send_req(input logic [1:0] op, input logic [31:0] addr);
    @(posedge clk); #1;
    bus.req_in    = '{opcode: op, address: addr};
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    model_req(op, addr);
  endtask

  task automatic wait_pace(input int max_out);
    int b = 0;
    while ((n_exp_done - n_done) >= max_out && b < 3000) begin
      @(negedge clk); b++;
    end
    chk("pace_bound", 32'(b < 3000), 32'd1);
  endtask

  task automatic cmp_ev(input int i, input ev_t o, input ev_t e);
    chk($sformatf("ev%0d_kind", i), 32'(o.kind), 32'(e.kind));
    if (e.kind != K_DONE) begin
      chk($sformatf("ev%0d_bg", i), 32'(o.bg), 32'(e.bg));
      chk($sformatf("ev%0d_bank", i), 32'(o.bank), 32'(e.bank));
    end
    if (e.kind == K_ACT) chk($sformatf("ev%0d_row", i), 32'(o.row), 32'(e.row));
    if (e.kind == K_RW) begin
      chk($sformatf("ev%0d_col", i), 32'(o.col), 32'(e.col));
      chk($sformatf("ev%0d_wr", i), 32'(o.wr), 32'(e.wr));
    end
    if (e.gap != GAP_X) chk($sformatf("ev%0d_gap", i), 32'(o.gap), 32'(e.gap));
  endtask

  // scoreboard: wait for all modelled completions, then compare event streams in order
  task automatic drain(input string name);
    int b = 0;
    while (n_done < n_exp_done && b < 4000) begin
      @(negedge clk); b++;
    end
    chk({name, "_drain_bound"}, 32'(b < 4000), 32'd1);
    repeat (8) @(negedge clk);
    chk({name, "_event_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) cmp_ev(i, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string p);
    chk({p, "_cmd_valid"}, 32'(bus.cmd_valid), 32'd0);
    chk({p, "_cmd"},       32'(bus.cmd), 32'd0);
    chk({p, "_cmd_wr"},    32'(bus.cmd_wr), 32'd0);
    chk({p, "_cmd_bg"},    32'(bus.cmd_bg), 32'd0);
    chk({p, "_cmd_bank"},  32'(bus.cmd_bank), 32'd0);
    chk({p, "_cmd_row"},   32'(bus.cmd_row), 32'd0);
    chk({p, "_cmd_col"},   32'(bus.cmd_col), 32'd0);
    chk({p, "_req_done"},  32'(bus.req_done), 32'd0);
    chk({p, "_buf_full"},  32'(bus.buf_full), 32'd0);
    chk({p, "_buf_empty"}, 32'(bus.buf_empty), 32'd1);
    chk({p, "_drop_count"}, 32'(bus.drop_count), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int bg, bank, row, col;
    bg   = 3 * int'($urandom_range(0, 1));
    bank = 3 * int'($urandom_range(0, 1));
    row  = int'($urandom_range(1, 3));
    col  = int'($urandom_range(0, 1023));
    return mk_addr(bg, bank, row, col) | (32'($urandom_range(0, 3)) << 30);
  endfunction

  initial begin
    logic [31:0] a;
    logic [1:0]  op;
    int          occ, accepted, exp_drops, saved_done, b;

    for (int i = 0; i < 16; i++) begin ot_v[i] = 1'b0; ot_row[i] = '0; end
    bus.req_in    = '0;
    bus.req_valid = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst");

    // closed-bank read: ACT, RD 48 later, done 56 later
    send_req(OP_READ, mk_addr(0, 0, 5, 16));
    @(negedge clk);
    chk("buf_empty_after_push", 32'(bus.buf_empty), 32'd0);
    drain("closed_read");

    // row hit, new column: RD only
    send_req(OP_IFETCH, mk_addr(0, 0, 5, 42));
    drain("row_hit");

    // row conflict write: PRE, ACT, WR, done
    send_req(OP_WRITE, mk_addr(0, 0, 9, 300));
    drain("row_conflict");

    // bank independence: open BG3/bank3, then alternate hits
    send_req(OP_READ, mk_addr(3, 3, 7, 1));
    for (int i = 0; i < 4; i++) begin
      wait_pace(IN_DEPTH);
      if (i % 2 == 0) send_req(OP_READ, mk_addr(0, 0, 9, 100 + i));
      else            send_req(OP_READ, mk_addr(3, 3, 7, 200 + i));
    end
    drain("bank_indep");

    // randomized traffic without overflow
    for (int i = 0; i < 14; i++) begin
      op = 2'($urandom_range(0, 2));
      a  = rand_addr();
      wait_pace(IN_DEPTH);
      send_req(op, a);
      repeat ($urandom_range(1, 40)) @(posedge clk);
    end
    drain("random");
    chk("drop_before_overflow", 32'(bus.drop_count), 32'd0);

    // overflow: six back-to-back strobes while a long request occupies the scheduler
    send_req(OP_READ, mk_addr(0, 3, 2, 5));
    repeat (10) @(posedge clk);
    #1;
    occ       = 0;
    accepted  = 0;
    exp_drops = 0;
    for (int j = 0; j < 6; j++) begin
      op = 2'($urandom_range(0, 2));
      a  = rand_addr();
      bus.req_in    = '{opcode: op, address: a};
      bus.req_valid = 1'b1;
      if (occ < IN_DEPTH) begin
        model_req(op, a);
        occ++;
        accepted++;
      end else begin
        exp_drops++;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("ovf_buf_full", 32'(bus.buf_full), 32'd1);
    chk("ovf_drop_count", 32'(bus.drop_count), 32'(exp_drops));
    chk("ovf_accepted", 32'(accepted), 32'(IN_DEPTH));
    drain("overflow");
    chk("ovf_buf_empty_after", 32'(bus.buf_empty), 32'd1);

    // asynchronous reset in the middle of WAIT_RCD
    send_req(OP_READ, mk_addr(1, 2, 85, 77));
    b = 0;
    while (obs_q.size() == 0 && b < 300) begin @(negedge clk); b++; end
    chk("pre_reset_act_bound", 32'(b < 300), 32'd1);
    chk("pre_reset_kind", 32'(obs_q.size() > 0 ? obs_q[0].kind : 3'd0), 32'(K_ACT));
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 16; i++) ot_v[i] = 1'b0;
    n_exp_done = n_done;
    saved_done = n_done;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    chk("no_done_after_reset", 32'(n_done), 32'(saved_done));
    chk("no_cmd_after_reset", 32'(obs_q.size()), 32'd0);
    send_req(OP_READ, mk_addr(1, 2, 85, 77));
    wait_pace(IN_DEPTH);
    send_req(OP_READ, mk_addr(0, 0, 9, 123));
    drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
